// File: rtl/p0_serial_tx_if.sv
// P0 write port and serial-line status bundle between the core and the P0 serializer.
interface p0_serial_tx_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        tx;
  logic        busy;
  logic        full;
  logic        empty;
  logic        overflow;

  modport master (
    output wr_en, wr_data,
    input  tx, busy, full, empty, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output tx, busy, full, empty, overflow
  );
endinterface

// File: rtl/p0_serial_tx.sv
// Queues P0 writes and sends each word as two 8N1 frames, low byte first; start bit begins 2 edges after a write when idle.
// No backpressure to the core: a write while full is dropped and latches the sticky overflow flag.
module p0_serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input logic           clk,
  input logic           rst,
  p0_serial_tx_if.slave p0
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic          byte_sel, sel_nxt;
  logic [15:0]   shift_reg, shift_nxt;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;

  logic          full, empty, push, pop, bit_end, tx_line;
  logic [7:0]    cur_byte;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  // A write while full is refused even when a pop frees a slot on the same edge.
  assign push     = p0.wr_en && !full;
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign cur_byte = byte_sel ? shift_reg[15:8] : shift_reg[7:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= p0.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (p0.wr_en && full)  overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_sel  <= 1'b0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_idx   <= bit_nxt;
      byte_sel  <= sel_nxt;
      shift_reg <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    sel_nxt   = byte_sel;
    shift_nxt = shift_reg;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          sel_nxt   = 1'b0;
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        // High byte follows the low byte with no idle gap in between.
        if (bit_end) begin
          baud_nxt = '0;
          if (!byte_sel) begin
            sel_nxt   = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      START:   tx_line = 1'b0;
      DATA:    tx_line = cur_byte[bit_idx];
      default: tx_line = 1'b1;
    endcase
  end

  assign p0.tx       = tx_line;
  assign p0.busy     = (state != IDLE) || !empty;
  assign p0.full     = full;
  assign p0.empty    = empty;
  assign p0.overflow = overflow_q;
endmodule
